// File: rtl/dbg_uart_sched_pkg.sv
// Shared types and helpers for the debug UART scheduler.
// Build option: DBG_SCHED_NEWLINE_EN appends a newline byte after every word.
package dbg_uart_sched_pkg;

`ifdef DBG_SCHED_NEWLINE_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TAG  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_NL   = 3'd4
  } sched_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TAG  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3
  } sched_state_e;
`endif

  localparam logic [7:0] ASCII_NL = 8'h0A;

  // Lowercase ASCII hex digit; 8'h57 + 10 = 8'h61 ('a').
  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Small synchronous FIFO with combinational head output, one per requester.
module dbg_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Extra pointer MSB tells full apart from empty when the indices match.
  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dbg_uart_sched.sv
// Round-robin scheduler sharing the debug UART between NREQ word requesters.
// Build option: DBG_SCHED_NEWLINE_EN adds a trailing 8'h0A byte per word.
module dbg_uart_sched
  import dbg_uart_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  output logic               tx_we,
  output logic [7:0]         tx_byte,
  input  logic               tx_wait,
  output logic [7:0]         drop_cnt,
  output logic               idle
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  sched_state_e   state_q, state_d;
  logic [DW-1:0]  cur_q, cur_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [7:0]     drop_q, drop_d;

  logic [NREQ-1:0] push, pop, empty, full;
  logic [DW-1:0]   head [NREQ];

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [8:0]      drop_sum;

  assign push      = req_valid & ~full;
  assign req_ready = ~full;
  assign drop_cnt  = drop_q;
  assign idle      = (state_q == S_IDLE) && (&empty);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    dbg_fifo #(
      .DEPTH(DEPTH),
      .W    (DW)
    ) u_fifo (
      .clk  (clk),
      .rstn (rstn),
      .push (push[gi]),
      .din  (req_data[gi*DW +: DW]),
      .pop  (pop[gi]),
      .dout (head[gi]),
      .empty(empty[gi]),
      .full (full[gi])
    );
  end

  // Search starts one past the last grant so every requester gets its turn.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && !empty[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[i] && full[i]) begin
        drop_sum = drop_sum + 9'd1;
      end
    end
    drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    pop     = '0;
    tx_we   = 1'b0;
    tx_byte = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          pop[gnt_idx] = 1'b1;
          cur_d        = head[gnt_idx];
          ptr_d        = gnt_idx;
          state_d      = S_TAG;
        end
      end
      S_TAG: begin
        tx_we   = 1'b1;
        tx_byte = cur_q[DW-1:DW-8];
        if (!tx_wait) state_d = S_HI;
      end
      S_HI: begin
        tx_we   = 1'b1;
        tx_byte = hex_digit(cur_q[7:4]);
        if (!tx_wait) state_d = S_LO;
      end
      S_LO: begin
        tx_we   = 1'b1;
        tx_byte = hex_digit(cur_q[3:0]);
`ifdef DBG_SCHED_NEWLINE_EN
        if (!tx_wait) state_d = S_NL;
`else
        if (!tx_wait) state_d = S_IDLE;
`endif
      end
`ifdef DBG_SCHED_NEWLINE_EN
      S_NL: begin
        tx_we   = 1'b1;
        tx_byte = ASCII_NL;
        if (!tx_wait) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= PTR_RST;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_dbg_uart_sched.sv
// Self-checking bench for dbg_uart_sched (NREQ=2, DEPTH=8): directed cases plus
// randomized traffic checked against per-requester word queues.
module tb_dbg_uart_sched;

  localparam int NR = 2;
  localparam int DP = 8;
`ifdef DBG_SCHED_NEWLINE_EN
  localparam int BPW = 4;
`else
  localparam int BPW = 3;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR*16-1:0] req_data;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic           tx_we;
  logic [7:0]     tx_byte;
  logic           tx_wait;
  logic [7:0]     drop_cnt;
  logic           idle;

  int total = 0;
  int bad   = 0;
  int hold_err = 0;

  logic [7:0]  acc_q [$];
  logic [7:0]  exp_q [$];
  logic [15:0] mq [NR][$];
  string hexs = "0123456789abcdef";

  logic       pv_we, pv_wait;
  logic [7:0] pv_byte;

  dbg_uart_sched #(
    .NREQ (NR),
    .DEPTH(DP),
    .DW   (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .tx_we    (tx_we),
    .tx_byte  (tx_byte),
    .tx_wait  (tx_wait),
    .drop_cnt (drop_cnt),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // UART side: log accepted bytes and flag any change of a held byte.
  always @(negedge clk) begin
    if (!rstn) begin
      pv_we   <= 1'b0;
      pv_wait <= 1'b0;
      pv_byte <= 8'h00;
    end else begin
      if (pv_we && pv_wait && !(tx_we && tx_byte == pv_byte)) hold_err <= hold_err + 1;
      if (tx_we && !tx_wait) acc_q.push_back(tx_byte);
      pv_we   <= tx_we;
      pv_wait <= tx_wait;
      pv_byte <= tx_byte;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(8'(hexs[w[7:4]]));
    exp_q.push_back(8'(hexs[w[3:0]]));
`ifdef DBG_SCHED_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    tx_wait   = 1'b0;
    rstn      = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (!idle && n < budget) begin
      tx_wait = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      step();
      n++;
    end
    tx_wait = 1'b0;
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, acc_q.size(), exp_q.size());
    n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(acc_q[i]), 32'(exp_q[i]));
    acc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int cnt [NR];
    int words;
    bit any;

    req_data  = '0;
    req_valid = '0;
    tx_wait   = 1'b0;
    rstn      = 1'b0;
    #3;
    check("rst_tx_we", 32'(tx_we), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(req_ready), 32'h3);
    do_reset();

    // Single word, exact latency.
    req_data[15:0] = 16'h4B3F;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    @(negedge clk);
    check("grant_cycle_we", 32'(tx_we), 32'd0);
    check("grant_cycle_idle", 32'(idle), 32'd0);
    add_word(16'h4B3F);
    for (int b = 0; b < BPW; b++) begin
      step();
      @(negedge clk);
      check("single_byte", {23'd0, tx_we, tx_byte}, {23'd0, 1'b1, exp_q[b]});
    end
    step();
    @(negedge clk);
    check("single_done_we", 32'(tx_we), 32'd0);
    check("single_done_idle", 32'(idle), 32'd1);
    step();
    compare_stream("single_stream");

    // Zero word is transmitted.
    req_data[15:0] = 16'h0000;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    add_word(16'h0000);
    wait_idle(50, 1'b0);
    compare_stream("zero_word");

    // Busy UART: each byte held 5 cycles.
    tx_wait = 1'b1;
    req_data[15:0] = 16'h4B3F;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    add_word(16'h4B3F);
    for (int b = 0; b < BPW; b++) begin
      repeat (5) begin
        @(negedge clk);
        check("busy_hold", {23'd0, tx_we, tx_byte}, {23'd0, 1'b1, exp_q[b]});
        step();
      end
      tx_wait = 1'b0;
      @(negedge clk);
      step();
      tx_wait = 1'b1;
    end
    @(negedge clk);
    check("busy_done_we", 32'(tx_we), 32'd0);
    step();
    tx_wait = 1'b0;
    compare_stream("busy_stream");
    check("hold_err", 32'(hold_err), 32'd0);

    // Round-robin from reset.
    do_reset();
    req_data  = {16'h4201, 16'h4101};
    req_valid = 2'b11;
    step();
    req_data  = {16'h4202, 16'h4102};
    step();
    req_valid = '0;
    add_word(16'h4101);
    add_word(16'h4201);
    add_word(16'h4102);
    add_word(16'h4202);
    wait_idle(100, 1'b0);
    compare_stream("rr_stream");

    // Overflow while the scheduler is stuck on another word.
    do_reset();
    tx_wait = 1'b1;
    req_data[15:0] = 16'h3001;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    for (int k = 0; k < 10; k++) begin
      req_data[31:16] = 16'h5100 + 16'(k);
      req_valid = 2'b10;
      @(negedge clk);
      check("ovf_ready", 32'(req_ready[1]), (k < DP) ? 32'd1 : 32'd0);
      step();
    end
    req_valid = '0;
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    add_word(16'h3001);
    for (int k = 0; k < DP; k++) add_word(16'h5100 + 16'(k));
    wait_idle(200, 1'b0);
    compare_stream("ovf_stream");

    // Drop counting, saturation, asynchronous reset mid-word.
    do_reset();
    tx_wait  = 1'b1;
    req_data = {16'h52A7, 16'h52A7};
    req_valid = 2'b10;
    repeat (100) step();
    check("drop_single", 32'(drop_cnt), 32'd91);
    req_valid = 2'b11;
    repeat (10) step();
    check("drop_dual", 32'(drop_cnt), 32'd103);
    repeat (200) step();
    check("drop_sat", 32'(drop_cnt), 32'd255);
    req_valid = '0;
    tx_wait = 1'b0;
    step();
    tx_wait = 1'b1;
    @(negedge clk);
    check("mid_hi_byte", {23'd0, tx_we, tx_byte}, {23'd0, 1'b1, 8'h61});
    #2;
    rstn = 1'b0;
    #1;
    check("arst_tx_we", 32'(tx_we), 32'd0);
    check("arst_tx_byte", 32'(tx_byte), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    check("arst_ready", 32'(req_ready), 32'h3);
    @(negedge clk);
    step();
    rstn = 1'b1;
    tx_wait = 1'b0;
    acc_q.delete();
    exp_q.delete();

`ifdef DBG_SCHED_NEWLINE_EN
    req_data[15:0] = 16'h2000;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    wait_idle(50, 1'b0);
    check("nl_len", acc_q.size(), 32'd4);
    if (acc_q.size() == 4) begin
      check("nl_b0", 32'(acc_q[0]), 32'h20);
      check("nl_b1", 32'(acc_q[1]), 32'h30);
      check("nl_b2", 32'(acc_q[2]), 32'h30);
      check("nl_b3", 32'(acc_q[3]), 32'h0A);
    end
    acc_q.delete();
`endif

    // Randomized traffic against per-requester FIFO order.
    for (int r = 0; r < 8; r++) begin
      words = 0;
      for (int i = 0; i < NR; i++) cnt[i] = $urandom_range(0, DP);
      do begin
        any = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
          if (cnt[i] > 0 && $urandom_range(0, 1) == 1) begin
            w = {5'b11000, 3'(i), 8'($urandom)};
            req_data[16*i +: 16] = w;
            req_valid[i] = 1'b1;
            mq[i].push_back(w);
            cnt[i]--;
            words++;
          end
          if (cnt[i] > 0) any = 1'b1;
        end
        tx_wait = ($urandom_range(0, 2) == 0);
        step();
      end while (any);
      req_valid = '0;
      wait_idle(3000, 1'b1);
      check("rnd_len", acc_q.size(), 32'(words * BPW));
      for (int g = 0; g + BPW <= acc_q.size(); g += BPW) begin
        int rq;
        rq = int'(acc_q[g][2:0]);
        if (rq < NR && mq[rq].size() > 0) begin
          w = mq[rq].pop_front();
          add_word(w);
          for (int b = 0; b < BPW; b++) check("rnd_byte", 32'(acc_q[g + b]), 32'(exp_q[b]));
          exp_q.delete();
        end else begin
          check("rnd_unexpected_tag", 32'(acc_q[g]), 32'hFFFF_FFFF);
        end
      end
      for (int i = 0; i < NR; i++) begin
        check("rnd_leftover", mq[i].size(), 32'd0);
        mq[i].delete();
      end
      acc_q.delete();
    end
    check("rnd_drop", 32'(drop_cnt), 32'd0);
    check("rnd_hold_err", 32'(hold_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_uart_sched.md
Name: dbg_uart_sched

Overview:
Scheduler that shares the single debug UART transmit channel between NREQ debug-word requesters, such as the CPU debug port and the i2c/spi/sram module debug ports.
- Each requester pushes 16-bit words into its own small FIFO.
- A round-robin scheduler selects one word at a time and serialises it onto the UART write interface as three bytes: tag byte, hex digit of [7:4], hex digit of [3:0].
- It replaces ad-hoc priority muxing at SoC level, and words that cannot be buffered are counted instead of silently lost.

Parameters:
NREQ, 2, number of requesters (1..8)
DEPTH, 8, per-requester FIFO depth in words, power of two, >=2
DW, 16, debug word width; fixed at 16, so [15:8] is the tag and [7:0] is hex-encoded

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req_data  in  NREQ*16  requester words; requester i uses bits [16*i+15:16*i]
req_valid  in  NREQ  push strobe per requester, one word per cycle when high
req_ready  out  NREQ  requester FIFO not full
tx_we  out  1  UART write request
tx_byte  out  8  byte to transmit
tx_wait  in  1  UART busy; a write is accepted in a cycle with tx_we=1 and tx_wait=0
drop_cnt  out  8  saturating count of rejected pushes
idle  out  1  all FIFOs empty and scheduler in S_IDLE

Behaviour:
- Interface decision: one clock, clk; reset rstn is asynchronous, active-low. All state is cleared on rstn low regardless of clk.
- Reset values: tx_we=0, tx_byte=0, drop_cnt=0, idle=1, req_ready=all ones, RR pointer=NREQ-1 (so requester 0 wins first), state S_IDLE.
- FIFO push:
  - Occurs when req_valid[i] && req_ready[i].
  - req_ready[i] = !full[i], combinational from registered FIFO state.
  - A pop in the same cycle does not free space for a push in that cycle; no bypass.
- Drops: each cycle in which req_valid[i] && !req_ready[i], drop_cnt increments by the number of such i. It saturates at 255 and never wraps.
- Arbitration happens only in S_IDLE:
  - Search from ptr+1 upward modulo NREQ and pick the first requester with a non-empty FIFO.
  - Pop its head into the cur register, set ptr to the granted index, and go to S_TAG.
  - If no FIFO is non-empty, stay in S_IDLE.
- S_TAG: tx_we=1, tx_byte=cur[15:8]. When tx_wait=0, go to S_HI.
- S_HI: tx_we=1, tx_byte=hex(cur[7:4]). When tx_wait=0, go to S_LO.
- S_LO: tx_we=1, tx_byte=hex(cur[3:0]). When tx_wait=0, go to S_IDLE, or to S_NL if the optional feature is enabled.
- Handshake rules:
  - tx_byte is stable while tx_we=1 and tx_wait=1.
  - tx_we falls only on the transition to S_IDLE.
  - Consecutive bytes of one word may be presented back to back.
- Hex encoding is lowercase: 0-9 map to 8'h30-8'h39, a-f map to 8'h61-8'h66.
- Latency: a push at cycle t into an empty system gives grant at t+1 and tx_we=1 with the tag byte at t+2.
- Fairness: with all FIFOs continuously non-empty, the grant order is 0,1,..,NREQ-1,0,...
- A word of value 16'h0000 is a legal word and is transmitted.
- idle = (state==S_IDLE) && all FIFOs empty.
- FIFO pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty, and wrap-around is natural modulo 2*DEPTH.
- Reset mid-word: the partial byte sequence is abandoned, and FIFO contents and the drop count are lost.

Optional Feature:
DBG_SCHED_NEWLINE_EN
- Defined: adds state S_NL after S_LO. S_NL drives tx_we=1 and tx_byte=8'h0A, and goes to S_IDLE when tx_wait=0. Each word is 4 bytes.
- Undefined: S_NL does not exist and each word is 3 bytes.

Decomposition:
- Shared package/include holds the state encoding localparams (S_IDLE, S_TAG, S_HI, S_LO, S_NL), the ASCII newline constant, and the hex-digit function.
- One sub-module, dbg_fifo, instantiated NREQ times:
  - Parameters: DEPTH, W.
  - Ports: clk, rstn, push, din, pop, dout (head, combinational), empty, full.
- The arbiter and serialiser stay in the top module.

Test Plan:
- Single word: push 16'h4B3F on req 0 with tx_wait=0 -> bytes 8'h4B, 8'h33, 8'h66 on consecutive cycles starting at t+2; idle=1 afterwards.
- Busy UART: same word with tx_wait held 1 for 5 cycles on each byte -> tx_byte stable throughout; exactly 3 accepted writes, with no duplicate and no skip.
- Round-robin: preload req0 with 16'h4101 and 16'h4102, and req1 with 16'h4201 and 16'h4202 -> tag order 41,42,41,42.
- Overflow: push 10 words into req1 with DEPTH=8 while tx_wait=1 -> req_ready[1]=0 after 8 words; drop_cnt=2; the 8 buffered words are later sent in order.
- Saturation and reset: force 300 rejected pushes -> drop_cnt=255; assert rstn low mid-S_HI -> tx_we=0 and drop_cnt=0 asynchronously, and idle=1.
- With DBG_SCHED_NEWLINE_EN defined: push 16'h2000 -> bytes 20,30,30,0A.
